// File: rtl/user_id_entry.sv
// -----------------------------------------------------------------------------
// user_id_entry
//
// Keypad front-end for the ROM user ID controller. It collects four hex
// digits into a 16-bit ID and presents it on `entered`. On submit it raises
// `valid_bit` to start the controller's ROM search. It then watches
// `green_led_user` for a match. A timeout counts as a rejection. After a
// logout, an abort or a rejection, it pulses `log_out` to send the
// controller back to INIT.
//
// Parameters
//   TIMEOUT        cycles spent in WAIT_RESULT before declaring rejection
//                  (must exceed the controller's worst-case search time)
//   LOGOUT_CYCLES  cycles that log_out is held high (>= 1)
//
// Ports
//   clock           in   system clock, rising edge
//   rst             in   synchronous active-high reset
//   key_valid       in   strobe, key_code holds a digit
//   key_code[3:0]   in   hex digit
//   key_enter       in   strobe, submit the ID
//   key_clear       in   strobe, discard digits entered so far
//   key_logout      in   strobe, end session / abort search
//   green_led_user  in   match indication from the controller
//   entered[15:0]   out  assembled ID, first digit in [15:12]
//   valid_bit       out  search request to the controller
//   log_out         out  return-to-INIT request to the controller
//   digit_count     out  digits captured, 0..4
//   session_active  out  user logged in
//   reject          out  one-cycle pulse on lookup failure
// -----------------------------------------------------------------------------
module user_id_entry #(
    parameter int TIMEOUT       = 48,
    parameter int LOGOUT_CYCLES = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        key_enter,
    input  logic        key_clear,
    input  logic        key_logout,
    input  logic        green_led_user,
    output logic [15:0] entered,
    output logic        valid_bit,
    output logic        log_out,
    output logic [2:0]  digit_count,
    output logic        session_active,
    output logic        reject
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int LW = $clog2(LOGOUT_CYCLES + 1);

    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LOGOUT_LAST = LW'(LOGOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_READY   = 3'd1,
        S_WAIT    = 3'd2,
        S_SESSION = 3'd3,
        S_LOGOUT  = 3'd4
    } state_t;

    state_t        state_q,   state_d;
    logic [15:0]   entered_q, entered_d;
    logic          valid_q,   valid_d;
    logic          logout_q,  logout_d;
    logic [2:0]    count_q,   count_d;
    logic          session_q, session_d;
    logic          reject_q,  reject_d;
    logic [TW-1:0] timer_q,   timer_d;
    logic [LW-1:0] lcnt_q,    lcnt_d;

    always_comb begin
        state_d   = state_q;
        entered_d = entered_q;
        valid_d   = valid_q;
        logout_d  = logout_q;
        count_d   = count_q;
        session_d = session_q;
        reject_d  = 1'b0;              // reject is a single-cycle pulse
        timer_d   = '0;                // timer runs only in WAIT_RESULT
        lcnt_d    = lcnt_q;

        case (state_q)
            S_COLLECT: begin
                // key_enter cannot act here because fewer than 4 digits are
                // captured. key_valid is therefore the only other event that
                // can take effect. key_logout has no meaning before a search.
                if (key_clear) begin
                    entered_d = '0;
                    count_d   = '0;
                end else if (key_valid) begin
                    entered_d = {entered_q[11:0], key_code};
                    count_d   = count_q + 3'd1;
                    if (count_q == 3'd3)
                        state_d = S_READY;
                end
            end

            S_READY: begin
                if (key_clear) begin
                    entered_d = '0;
                    count_d   = '0;
                    state_d   = S_COLLECT;
                end else if (key_enter) begin
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                // entered and valid_bit stay put while the controller searches.
                timer_d = timer_q + TW'(1);
                if (key_logout) begin
                    valid_d  = 1'b0;
                    logout_d = 1'b1;
                    lcnt_d   = '0;
                    state_d  = S_LOGOUT;
                end else if (green_led_user) begin
                    valid_d   = 1'b0;
                    session_d = 1'b1;
                    state_d   = S_SESSION;
                end else if (timer_q == TIMER_LAST) begin
                    // A rejection also logs out, which frees the controller
                    // from its fail state.
                    valid_d  = 1'b0;
                    reject_d = 1'b1;
                    logout_d = 1'b1;
                    lcnt_d   = '0;
                    state_d  = S_LOGOUT;
                end
            end

            S_SESSION: begin
                if (key_logout) begin
                    session_d = 1'b0;
                    logout_d  = 1'b1;
                    lcnt_d    = '0;
                    state_d   = S_LOGOUT;
                end
            end

            S_LOGOUT: begin
                // log_out went high on the entry edge. Each cycle spent here
                // extends it by one, until LOGOUT_CYCLES cycles are complete.
                if (lcnt_q == LOGOUT_LAST) begin
                    logout_d  = 1'b0;
                    entered_d = '0;
                    count_d   = '0;
                    lcnt_d    = '0;
                    state_d   = S_COLLECT;
                end else begin
                    lcnt_d = lcnt_q + LW'(1);
                end
            end

            default: begin
                state_d   = S_COLLECT;
                entered_d = '0;
                valid_d   = 1'b0;
                logout_d  = 1'b0;
                count_d   = '0;
                session_d = 1'b0;
                lcnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= S_COLLECT;
            entered_q <= '0;
            valid_q   <= 1'b0;
            logout_q  <= 1'b0;
            count_q   <= '0;
            session_q <= 1'b0;
            reject_q  <= 1'b0;
            timer_q   <= '0;
            lcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            entered_q <= entered_d;
            valid_q   <= valid_d;
            logout_q  <= logout_d;
            count_q   <= count_d;
            session_q <= session_d;
            reject_q  <= reject_d;
            timer_q   <= timer_d;
            lcnt_q    <= lcnt_d;
        end
    end

    assign entered        = entered_q;
    assign valid_bit      = valid_q;
    assign log_out        = logout_q;
    assign digit_count    = count_q;
    assign session_active = session_q;
    assign reject         = reject_q;

endmodule
